lmmi2wb: RTL and testbench

- LMMI target that turns each accepted LMMI transaction into a single classic Wishbone master cycle, and returns read data on the LMMI read-data channel.
- Lets LMMI-initiating logic reach Wishbone peripherals. It is the mirror of the existing WB-target/LMMI-initiator bridge.
- Adds a bus timeout and sticky error/timeout status so a hung or erroring slave cannot stall the LMMI side.

---
 rtl/lmmi_wb_pkg.sv | 28 ++
 rtl/lmmi2wb.sv | 135 +++++++++++++
 tb/tb_lmmi2wb.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lmmi_wb_pkg.sv
// Shared types and widths for the LMMI-target to Wishbone-master bridge.
package lmmi_wb_pkg;

    localparam int unsigned LMMI_OFS_W = 16;
    localparam int unsigned WB_ADR_W   = 18;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WB_SEL_W   = 4;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE,
        WB_CYCLE
    } state_e;

    // Request payload latched at LMMI acceptance and replayed on the WB bus
    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [DATA_W-1:0]   dat;
    } wb_req_t;

    // LMMI addresses 32-bit words; Wishbone takes byte addresses
    function automatic logic [WB_ADR_W-1:0] ofs_to_adr(input logic [LMMI_OFS_W-1:0] ofs);
        return {ofs, 2'b00};
    endfunction

endpackage

// File: rtl/lmmi2wb.sv
// LMMI target that issues one classic Wishbone master cycle per accepted request,
// with a bus timeout and sticky error/timeout status.
module lmmi2wb
    import lmmi_wb_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 256,
    parameter logic [DATA_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  lmmi_request,
    input  logic                  lmmi_wr_rdn,
    input  logic [LMMI_OFS_W-1:0] lmmi_offset,
    input  logic [DATA_W-1:0]     lmmi_wdata,
    output logic                  lmmi_ready,
    output logic [DATA_W-1:0]     lmmi_rdata,
    output logic                  lmmi_rdata_valid,

    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [WB_ADR_W-1:0]   wb_adr,
    output logic [DATA_W-1:0]     wb_dat_w,
    output logic [WB_SEL_W-1:0]   wb_sel,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    input  logic [DATA_W-1:0]     wb_dat_r,

    input  logic                  status_clr,
    output logic                  err_sticky,
    output logic                  to_sticky
);

    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_EN ? TIMEOUT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    wb_req_t           req_q, req_d;
    logic              cyc_q, cyc_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              to_q, to_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= '0;
            cyc_q    <= 1'b0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            cyc_q    <= cyc_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            to_q     <= to_d;
        end
    end

    // Next-state and next-output logic; a new set of a sticky flag beats status_clr
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        cyc_d    = cyc_q;
        ready_d  = ready_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        cnt_d    = cnt_q;
        err_d    = err_q & ~status_clr;
        to_d     = to_q & ~status_clr;

        unique case (state_q)
            IDLE: begin
                if (lmmi_request && ready_q) begin
                    state_d    = WB_CYCLE;
                    req_d.we   = lmmi_wr_rdn;
                    req_d.adr  = ofs_to_adr(lmmi_offset);
                    req_d.dat  = lmmi_wdata;
                    cyc_d      = 1'b1;
                    ready_d    = 1'b0;
                    cnt_d      = '0;
                end
            end

            WB_CYCLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (wb_err || wb_ack || (TIMEOUT_EN && cnt_q == TO_LAST)) begin
                    state_d  = IDLE;
                    cyc_d    = 1'b0;
                    ready_d  = 1'b1;
                    rvalid_d = ~req_q.we;
                    if (!req_q.we) begin
                        rdata_d = (wb_ack && !wb_err) ? wb_dat_r : ERR_DATA;
                    end
                    if (wb_err) begin
                        err_d = 1'b1;
                    end else if (!wb_ack) begin
                        to_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lmmi_ready       = ready_q;
    assign lmmi_rdata       = rdata_q;
    assign lmmi_rdata_valid = rvalid_q;
    assign wb_cyc           = cyc_q;
    assign wb_stb           = cyc_q;
    assign wb_we            = req_q.we;
    assign wb_adr           = req_q.adr;
    assign wb_dat_w         = req_q.dat;
    assign wb_sel           = {WB_SEL_W{1'b1}};
    assign err_sticky       = err_q;
    assign to_sticky        = to_q;

endmodule

// File: tb/tb_lmmi2wb.sv
// Directed self-checking bench for lmmi2wb: one instance with an 8-cycle timeout,
// one with the timeout disabled.
module tb_lmmi2wb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        req0 = 1'b0;
    logic        wr_rdn = 1'b0;
    logic [15:0] ofs = '0;
    logic [31:0] wdata = '0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic        ack0 = 1'b0;
    logic        err0 = 1'b0;
    logic [31:0] dat_r = '0;
    logic        clr = 1'b0;

    logic        ready, rvalid, cyc, stb, we, err_st, to_st;
    logic [31:0] rdata, dat_w;
    logic [17:0] adr;
    logic [3:0]  sel;

    logic        ready0, rvalid0, cyc0, stb0, we0, err_st0, to_st0;
    logic [31:0] rdata0, dat_w0;
    logic [17:0] adr0;
    logic [3:0]  sel0;

    int n_tests = 0;
    int n_fail  = 0;
    int rv_cnt  = 0;
    int rv0_cnt = 0;

    lmmi2wb #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .lmmi_request(req), .lmmi_wr_rdn(wr_rdn), .lmmi_offset(ofs), .lmmi_wdata(wdata),
        .lmmi_ready(ready), .lmmi_rdata(rdata), .lmmi_rdata_valid(rvalid),
        .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr), .wb_dat_w(dat_w), .wb_sel(sel),
        .wb_ack(ack), .wb_err(err), .wb_dat_r(dat_r),
        .status_clr(clr), .err_sticky(err_st), .to_sticky(to_st)
    );

    lmmi2wb #(.TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .lmmi_request(req0), .lmmi_wr_rdn(wr_rdn), .lmmi_offset(ofs), .lmmi_wdata(wdata),
        .lmmi_ready(ready0), .lmmi_rdata(rdata0), .lmmi_rdata_valid(rvalid0),
        .wb_cyc(cyc0), .wb_stb(stb0), .wb_we(we0), .wb_adr(adr0), .wb_dat_w(dat_w0), .wb_sel(sel0),
        .wb_ack(ack0), .wb_err(err0), .wb_dat_r(dat_r),
        .status_clr(clr), .err_sticky(err_st0), .to_sticky(to_st0)
    );

    always #5 clk = ~clk;

    // Count read-data pulses just after each active edge
    always @(posedge clk) begin
        #1;
        if (rvalid)  rv_cnt++;
        if (rvalid0) rv0_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        int drops;
        int rv_snap;

        // Reset values
        #12;
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_cyc_stb_we", {29'h0, cyc, stb, we}, 32'h0);
        check("rst_adr", 32'(adr), 32'h0);
        check("rst_dat_w", dat_w, 32'h0);
        check("rst_sticky", {30'h0, err_st, to_st}, 32'h0);
        step(1);
        rst_n = 1'b1;
        step(2);

        // Write, slave acks after 3 cycles
        rv_snap = rv_cnt;
        req = 1'b1; wr_rdn = 1'b1; ofs = 16'h0010; wdata = 32'hA5A5_0001;
        step(1);
        req = 1'b0;
        check("wr_cyc_stb_we", {29'h0, cyc, stb, we}, 32'h7);
        check("wr_adr", 32'(adr), 32'h0000_0040);
        check("wr_sel", 32'(sel), 32'hF);
        check("wr_dat_w", dat_w, 32'hA5A5_0001);
        check("wr_ready_busy", 32'(ready), 32'h0);
        step(2);
        check("wr_cyc_held", 32'(cyc), 32'h1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("wr_cyc_drop", 32'(cyc), 32'h0);
        check("wr_ready_back", 32'(ready), 32'h1);
        check("wr_adr_hold", 32'(adr), 32'h0000_0040);
        step(2);
        check("wr_no_rvalid", 32'(rv_cnt - rv_snap), 32'h0);

        // Fastest read then back-to-back read
        req = 1'b1; wr_rdn = 1'b0; ofs = 16'h0003;
        step(1);
        req = 1'b0;
        check("rd_cyc_we", {30'h0, cyc, we}, 32'h2);
        check("rd_adr", 32'(adr), 32'h0000_000C);
        ack = 1'b1; dat_r = 32'h1234_5678;
        step(1);
        check("rd_rvalid", 32'(rvalid), 32'h1);
        check("rd_rdata", rdata, 32'h1234_5678);
        check("rd_cyc_drop", 32'(cyc), 32'h0);
        ack = 1'b0; req = 1'b1; ofs = 16'h0004;
        step(1);
        req = 1'b0;
        check("b2b_rvalid_one", 32'(rvalid), 32'h0);
        check("b2b_cyc", 32'(cyc), 32'h1);
        check("b2b_adr", 32'(adr), 32'h0000_0010);
        check("rdata_hold", rdata, 32'h1234_5678);
        ack = 1'b1; dat_r = 32'hCAFE_0002;
        step(1);
        ack = 1'b0;
        check("b2b_rdata", rdata, 32'hCAFE_0002);

        // Error with simultaneous ack: err wins
        step(1);
        req = 1'b1; ofs = 16'h0005;
        step(1);
        req = 1'b0; ack = 1'b1; err = 1'b1;
        step(1);
        ack = 1'b0; err = 1'b0;
        check("err_rvalid", 32'(rvalid), 32'h1);
        check("err_rdata", rdata, 32'hDEAD_BEEF);
        check("err_sticky_set", {30'h0, err_st, to_st}, 32'h2);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check("err_sticky_clr", 32'(err_st), 32'h0);
        req = 1'b1; ofs = 16'h0006;
        step(1);
        req = 1'b0; err = 1'b1; clr = 1'b1;
        step(1);
        err = 1'b0; clr = 1'b0;
        check("err_set_beats_clr", 32'(err_st), 32'h1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;

        // Read timeout after 8 cycles, then a late ack in IDLE
        req = 1'b1; ofs = 16'h0006;
        step(1);
        req = 1'b0;
        hi = 0;
        while (cyc && hi < 20) begin
            hi++;
            step(1);
        end
        check("to_cyc_len", 32'(hi), 32'd8);
        check("to_rvalid", 32'(rvalid), 32'h1);
        check("to_rdata", rdata, 32'hDEAD_BEEF);
        check("to_sticky_set", {30'h0, err_st, to_st}, 32'h1);
        rv_snap = rv_cnt;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(1);
        check("late_ack_ignored", 32'(rv_cnt - rv_snap), 32'h0);
        check("late_ack_idle", {30'h0, cyc, ready}, 32'h1);
        clr = 1'b1;
        step(1);
        clr = 1'b0;

        // Ack on the last allowed cycle beats the timeout
        req = 1'b1; ofs = 16'h0007;
        step(1);
        req = 1'b0; dat_r = 32'h0BAD_F00D;
        step(7);
        check("bnd_cyc_still", 32'(cyc), 32'h1);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        check("bnd_rvalid", 32'(rvalid), 32'h1);
        check("bnd_rdata", rdata, 32'h0BAD_F00D);
        check("bnd_no_to", 32'(to_st), 32'h0);

        // Timeout disabled: a 1000-cycle stall is never cut short
        req0 = 1'b1; wr_rdn = 1'b0; ofs = 16'h0008;
        step(1);
        req0 = 1'b0;
        drops = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!cyc0) drops++;
            step(1);
        end
        check("notimeout_drops", 32'(drops), 32'h0);
        check("notimeout_rvalid", 32'(rv0_cnt), 32'h0);
        check("notimeout_to", 32'(to_st0), 32'h0);
        dat_r = 32'h5555_AAAA; ack0 = 1'b1;
        step(1);
        ack0 = 1'b0;
        check("notimeout_end_rdata", rdata0, 32'h5555_AAAA);
        check("notimeout_end_cyc", 32'(cyc0), 32'h0);

        // Erroring write: flag only, no read pulse
        rv_snap = rv_cnt;
        req = 1'b1; wr_rdn = 1'b1; ofs = 16'h0020;
        step(1);
        req = 1'b0; err = 1'b1;
        step(1);
        err = 1'b0;
        check("wr_err_sticky", 32'(err_st), 32'h1);
        check("wr_err_silent", 32'(rv_cnt - rv_snap), 32'h0);

        // Reset in the middle of a read
        req = 1'b1; wr_rdn = 1'b0; ofs = 16'h0009;
        step(1);
        req = 1'b0;
        step(1);
        check("mid_cyc_before", 32'(cyc), 32'h1);
        rv_snap = rv_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_cyc_stb_async", {30'h0, cyc, stb}, 32'h0);
        check("mid_sticky_clr", {30'h0, err_st, to_st}, 32'h0);
        step(2);
        rst_n = 1'b1;
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        step(2);
        check("mid_ready", 32'(ready), 32'h1);
        check("mid_cyc_idle", 32'(cyc), 32'h0);
        check("mid_no_rvalid", 32'(rv_cnt - rv_snap), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
